// File: rtl/scurve_pkg.sv
// Shared definitions for the S-curve threshold scan controller:
// FSM state encoding, result header tag and default word widths.
package scurve_pkg;

    localparam int DAC_W_DEF = 10;
    localparam int CNT_W_DEF = 16;

    localparam logic [3:0] HDR_TAG = 4'hA;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_COUNT,
        ST_SEND_HDR,
        ST_SEND_PLS,
        ST_SEND_TRG,
        ST_NEXT,
        ST_FINISH
    } scan_state_e;

endpackage

// File: rtl/scurve_step_calc.sv
// Next threshold code toward the stop code: direction follows cur vs stop,
// a step of 0 is taken as 1 and an overshooting step lands exactly on stop.
module scurve_step_calc
    import scurve_pkg::*;
#(
    parameter int DAC_W = DAC_W_DEF
) (
    input  logic [DAC_W-1:0] cur_i,
    input  logic [DAC_W-1:0] stop_i,
    input  logic [DAC_W-1:0] step_i,
    output logic [DAC_W-1:0] next_o,
    output logic             last_o
);

    logic [DAC_W-1:0] step_eff;

    always_comb begin
        step_eff = (step_i == '0) ? DAC_W'(1) : step_i;
        last_o   = (cur_i == stop_i);
        next_o   = stop_i;
        if (cur_i < stop_i) begin
            if ((stop_i - cur_i) > step_eff) next_o = cur_i + step_eff;
        end else begin
            if ((cur_i - stop_i) > step_eff) next_o = cur_i - step_eff;
        end
    end

endmodule

// File: rtl/scurve_scan_ctrl.sv
// S-curve threshold scan sequencer: steps the DAC code, runs the external pulse
// counter at each code and streams header/pulse/trigger words over valid/ready.
module scurve_scan_ctrl
    import scurve_pkg::*;
#(
    parameter int DAC_W = DAC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             scan_start_i,
    input  logic             scan_abort_i,
    input  logic [DAC_W-1:0] dac_start_i,
    input  logic [DAC_W-1:0] dac_stop_i,
    input  logic [DAC_W-1:0] dac_step_i,
    input  logic [15:0]      settle_cycles_i,
    input  logic [CNT_W-1:0] cnt_max_in_i,
    output logic [DAC_W-1:0] dac_code_o,
    output logic             dac_load_o,
    output logic             test_start_o,
    output logic [CNT_W-1:0] cpt_max_o,
    input  logic [CNT_W-1:0] cpt_pulse_i,
    input  logic [CNT_W-1:0] cpt_trigger_i,
    input  logic             cpt_done_i,
    output logic [CNT_W-1:0] res_data_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic             scan_busy_o,
    output logic             scan_done_o
);

    scan_state_e      state_q, state_d;
    logic [DAC_W-1:0] dac_code_q, dac_code_d;
    logic [DAC_W-1:0] stop_q, stop_d;
    logic [DAC_W-1:0] step_q, step_d;
    logic [15:0]      settle_q, settle_d;
    logic [15:0]      settle_cnt_q, settle_cnt_d;
    logic [CNT_W-1:0] cnt_max_q, cnt_max_d;
    logic [CNT_W-1:0] pulse_q, pulse_d;
    logic [CNT_W-1:0] trig_q, trig_d;

    logic [DAC_W-1:0] next_code;
    logic             last_step;

    scurve_step_calc #(.DAC_W(DAC_W)) u_step_calc (
        .cur_i  (dac_code_q),
        .stop_i (stop_q),
        .step_i (step_q),
        .next_o (next_code),
        .last_o (last_step)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            dac_code_q   <= '0;
            stop_q       <= '0;
            step_q       <= '0;
            settle_q     <= '0;
            settle_cnt_q <= '0;
            cnt_max_q    <= '0;
            pulse_q      <= '0;
            trig_q       <= '0;
        end else begin
            state_q      <= state_d;
            dac_code_q   <= dac_code_d;
            stop_q       <= stop_d;
            step_q       <= step_d;
            settle_q     <= settle_d;
            settle_cnt_q <= settle_cnt_d;
            cnt_max_q    <= cnt_max_d;
            pulse_q      <= pulse_d;
            trig_q       <= trig_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        dac_code_d   = dac_code_q;
        stop_d       = stop_q;
        step_d       = step_q;
        settle_d     = settle_q;
        settle_cnt_d = settle_cnt_q;
        cnt_max_d    = cnt_max_q;
        pulse_d      = pulse_q;
        trig_d       = trig_q;

        case (state_q)
            ST_IDLE: begin
                if (scan_start_i && !scan_abort_i) begin
                    dac_code_d = dac_start_i;
                    stop_d     = dac_stop_i;
                    step_d     = dac_step_i;
                    settle_d   = settle_cycles_i;
                    cnt_max_d  = cnt_max_in_i;
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                settle_cnt_d = '0;
                state_d      = ST_SETTLE;
            end
            ST_SETTLE: begin
                // A settle time of 0 still spends one cycle here.
                if (({1'b0, settle_cnt_q} + 17'd1) >= {1'b0, settle_q}) begin
                    state_d = ST_COUNT;
                end else begin
                    settle_cnt_d = settle_cnt_q + 16'd1;
                end
            end
            ST_COUNT: begin
                if (cpt_done_i) begin
                    pulse_d = cpt_pulse_i;
                    trig_d  = cpt_trigger_i;
                    state_d = ST_SEND_HDR;
                end
            end
            ST_SEND_HDR: if (res_ready_i) state_d = ST_SEND_PLS;
            ST_SEND_PLS: if (res_ready_i) state_d = ST_SEND_TRG;
            ST_SEND_TRG: if (res_ready_i) state_d = ST_NEXT;
            ST_NEXT: begin
                if (last_step) begin
                    state_d = ST_FINISH;
                end else begin
                    dac_code_d = next_code;
                    state_d    = ST_LOAD;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        // Abort overrides everything and freezes the current code.
        if (scan_abort_i && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            dac_code_d = dac_code_q;
        end
    end

    always_comb begin
        dac_code_o   = dac_code_q;
        dac_load_o   = (state_q == ST_LOAD);
        test_start_o = (state_q == ST_COUNT);
        scan_busy_o  = (state_q != ST_IDLE);
        scan_done_o  = (state_q == ST_FINISH);
        cpt_max_o    = (state_q != ST_IDLE) ? cnt_max_q : '0;
        res_valid_o  = 1'b0;
        res_data_o   = '0;
        case (state_q)
            ST_SEND_HDR: begin
                res_valid_o = 1'b1;
                res_data_o  = CNT_W'(dac_code_q) | (CNT_W'(HDR_TAG) << (CNT_W - 4));
            end
            ST_SEND_PLS: begin
                res_valid_o = 1'b1;
                res_data_o  = pulse_q;
            end
            ST_SEND_TRG: begin
                res_valid_o = 1'b1;
                res_data_o  = trig_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_scurve_scan_ctrl.sv
// Randomized bench for scurve_scan_ctrl with a counter model and an expected
// word list derived from the scan rules (arithmetic code sequence ending at stop).
`timescale 1ns/1ps
module tb_scurve_scan_ctrl;

    localparam int DAC_W = 10;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             scan_start, scan_abort;
    logic [DAC_W-1:0] dac_start, dac_stop, dac_step;
    logic [15:0]      settle_cycles;
    logic [CNT_W-1:0] cnt_max_in;
    logic [DAC_W-1:0] dac_code_o;
    logic             dac_load_o, test_start_o;
    logic [CNT_W-1:0] cpt_max_o;
    logic [CNT_W-1:0] cpt_pulse, cpt_trigger;
    logic             cpt_done;
    logic [CNT_W-1:0] res_data_o;
    logic             res_valid_o, res_ready;
    logic             scan_busy_o, scan_done_o;

    always #5 clk = ~clk;

    scurve_scan_ctrl #(.DAC_W(DAC_W), .CNT_W(CNT_W)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .scan_start_i    (scan_start),
        .scan_abort_i    (scan_abort),
        .dac_start_i     (dac_start),
        .dac_stop_i      (dac_stop),
        .dac_step_i      (dac_step),
        .settle_cycles_i (settle_cycles),
        .cnt_max_in_i    (cnt_max_in),
        .dac_code_o      (dac_code_o),
        .dac_load_o      (dac_load_o),
        .test_start_o    (test_start_o),
        .cpt_max_o       (cpt_max_o),
        .cpt_pulse_i     (cpt_pulse),
        .cpt_trigger_i   (cpt_trigger),
        .cpt_done_i      (cpt_done),
        .res_data_o      (res_data_o),
        .res_valid_o     (res_valid_o),
        .res_ready_i     (res_ready),
        .scan_busy_o     (scan_busy_o),
        .scan_done_o     (scan_done_o)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [CNT_W-1:0] got_q[$];
    logic [CNT_W-1:0] exp_q[$];
    int exp_steps;
    int loads, dones;
    int ready_mode;
    int cnt_delay_max;
    logic trig_fixed;
    logic hold_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] trig_of(input logic [DAC_W-1:0] c);
        if (trig_fixed) return CNT_W'(500);
        return CNT_W'(int'(c) * 37 + 11);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counter model and res_ready driver, updated just after each rising edge.
    initial begin
        int wait_left;
        int stall;
        wait_left = 0;
        stall = 0;
        cpt_done = 1'b0;
        cpt_pulse = '0;
        cpt_trigger = '0;
        res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (test_start_o && !hold_done) begin
                if (wait_left == 0) begin
                    cpt_done    = 1'b1;
                    cpt_pulse   = cpt_max_o;
                    cpt_trigger = trig_of(dac_code_o);
                end else begin
                    wait_left--;
                end
            end else begin
                cpt_done  = 1'b0;
                wait_left = $urandom_range(0, cnt_delay_max);
            end
            case (ready_mode)
                0: res_ready = 1'b1;
                1: res_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (res_valid_o && (got_q.size() % 3 == 1) && stall < 20) begin
                        res_ready = 1'b0;
                        stall++;
                    end else begin
                        res_ready = 1'b1;
                        if (got_q.size() % 3 != 1) stall = 0;
                    end
                end
            endcase
        end
    end

    // Output monitor, sampled on the falling edge.
    initial begin
        logic prev_stall;
        logic [CNT_W-1:0] prev_data;
        int low_run;
        logic seen_high;
        prev_stall = 1'b0;
        prev_data = '0;
        low_run = 0;
        seen_high = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_stall && reset_n) begin
                chk("hold_valid", res_valid_o, 1);
                chk("hold_data", res_data_o, prev_data);
            end
            prev_stall = res_valid_o && !res_ready;
            prev_data  = res_data_o;
            if (res_valid_o && res_ready) got_q.push_back(res_data_o);
            if (dac_load_o) loads++;
            if (scan_done_o) dones++;
            if (test_start_o) begin
                if (seen_high && low_run > 0) chk("ts_gap", low_run >= 2, 1);
                seen_high = 1'b1;
                low_run = 0;
            end else begin
                low_run++;
            end
        end
    end

    task automatic build_exp(input int start, input int stop, input int step, input int cmax);
        int s;
        int codes[$];
        s = (step == 0) ? 1 : step;
        exp_q.delete();
        if (start <= stop) begin
            for (int v = start; v < stop; v += s) codes.push_back(v);
        end else begin
            for (int v = start; v > stop; v -= s) codes.push_back(v);
        end
        codes.push_back(stop);
        foreach (codes[i]) begin
            exp_q.push_back(CNT_W'(32'hA000 | codes[i]));
            exp_q.push_back(CNT_W'(cmax));
            exp_q.push_back(trig_of(DAC_W'(codes[i])));
        end
        exp_steps = codes.size();
    endtask

    task automatic check_reset_outputs(input string pfx);
        chk({pfx, "_code"}, dac_code_o, 0);
        chk({pfx, "_cptmax"}, cpt_max_o, 0);
        chk({pfx, "_data"}, res_data_o, 0);
        chk({pfx, "_load"}, dac_load_o, 0);
        chk({pfx, "_tstart"}, test_start_o, 0);
        chk({pfx, "_valid"}, res_valid_o, 0);
        chk({pfx, "_busy"}, scan_busy_o, 0);
        chk({pfx, "_done"}, scan_done_o, 0);
    endtask

    task automatic set_cfg(input int start, input int stop, input int step, input int settle,
                           input int cmax);
        dac_start     = DAC_W'(start);
        dac_stop      = DAC_W'(stop);
        dac_step      = DAC_W'(step);
        settle_cycles = 16'(settle);
        cnt_max_in    = CNT_W'(cmax);
    endtask

    task automatic run_scan(input string name, input int start, input int stop, input int step,
                            input int settle, input int cmax, input logic restart);
        int cyc;
        got_q.delete();
        loads = 0;
        dones = 0;
        build_exp(start, stop, step, cmax);
        set_cfg(start, stop, step, settle, cmax);
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        if (restart) begin
            tick();
            tick();
            set_cfg((start + 7) % 1024, (stop + 3) % 1024, step + 1, settle + 1, cmax + 1);
            scan_start = 1'b1;
            tick();
            scan_start = 1'b0;
        end
        cyc = 0;
        while (dones == 0 && cyc < 5000) begin
            tick();
            cyc++;
        end
        chk({name, "_timeout"}, cyc < 5000, 1);
        tick();
        tick();
        chk({name, "_nwords"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s_w%0d", name, i), got_q[i], exp_q[i]);
        end
        chk({name, "_dones"}, dones, 1);
        chk({name, "_loads"}, loads, exp_steps);
        chk({name, "_idle"}, scan_busy_o, 0);
        chk({name, "_cptmax_idle"}, cpt_max_o, 0);
        chk({name, "_endcode"}, dac_code_o, stop);
    endtask

    initial begin
        int cyc;
        logic [DAC_W-1:0] code_before;
        reset_n = 1'b0;
        scan_start = 1'b0;
        scan_abort = 1'b0;
        set_cfg(0, 0, 0, 0, 0);
        ready_mode = 0;
        cnt_delay_max = 4;
        trig_fixed = 1'b1;
        hold_done = 1'b0;
        loads = 0;
        dones = 0;
        tick();
        tick();
        check_reset_outputs("rst");
        reset_n = 1'b1;
        tick();
        chk("post_rst_busy", scan_busy_o, 0);

        run_scan("basic", 100, 103, 1, 5, 1000, 1'b0);
        run_scan("desc", 10, 0, 4, 2, 333, 1'b0);
        run_scan("single", 512, 512, 0, 0, 42, 1'b0);

        ready_mode = 2;
        run_scan("stall", 300, 310, 5, 3, 77, 1'b0);

        // Abort while the counter is running.
        ready_mode = 0;
        hold_done = 1'b1;
        dones = 0;
        set_cfg(200, 220, 2, 3, 9);
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        cyc = 0;
        while (!test_start_o && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("abort_reach_count", test_start_o, 1);
        code_before = dac_code_o;
        scan_abort = 1'b1;
        tick();
        scan_abort = 1'b0;
        chk("abort_tstart", test_start_o, 0);
        chk("abort_busy", scan_busy_o, 0);
        chk("abort_valid", res_valid_o, 0);
        chk("abort_code", dac_code_o, code_before);
        tick();
        tick();
        chk("abort_nodone", dones, 0);
        hold_done = 1'b0;
        run_scan("after_abort", 40, 52, 3, 1, 5, 1'b0);

        // Start and abort together in IDLE.
        loads = 0;
        scan_start = 1'b1;
        scan_abort = 1'b1;
        tick();
        scan_start = 1'b0;
        scan_abort = 1'b0;
        chk("both_busy", scan_busy_o, 0);
        tick();
        tick();
        chk("both_loads", loads, 0);

        // Randomized scans with random ready, some with an ignored restart.
        trig_fixed = 1'b0;
        ready_mode = 1;
        cnt_delay_max = 6;
        for (int k = 0; k < 6; k++) begin
            int st, sp, span, stp;
            st = $urandom_range(0, 1023);
            span = $urandom_range(0, 60);
            if ($urandom_range(0, 1) == 1) sp = (st + span > 1023) ? 1023 : st + span;
            else sp = (st < span) ? 0 : st - span;
            stp = $urandom_range(0, 15);
            run_scan($sformatf("rnd%0d", k), st, sp, stp, $urandom_range(0, 8),
                     $urandom_range(1, 65535), logic'(k % 2));
        end

        // Asynchronous reset while settling.
        ready_mode = 0;
        got_q.delete();
        loads = 0;
        set_cfg(50, 60, 1, 200, 10);
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        cyc = 0;
        while (loads == 0 && cyc < 50) begin
            tick();
            cyc++;
        end
        tick();
        tick();
        chk("rst_mid_busy", scan_busy_o, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        chk("rst_mid_nowords", got_q.size(), 0);
        chk("rst_mid_idle", scan_busy_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scurve_scan_ctrl.md
SCURVE_SCAN_CTRL -- requirements
Module: scurve_scan_ctrl

Interface
REQ-001 Parameter DAC_W, 10, threshold DAC code width.
REQ-002 Parameter CNT_W, 16, counter/result word width; SHALL be at least DAC_W+4.
REQ-003 clk  in  1  system clock (40 MHz).
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 scan_start  in  1  single-cycle request to begin a scan; ignored while busy.
REQ-006 scan_abort  in  1  single-cycle request to abandon the scan.
REQ-007 dac_start, dac_stop  in  DAC_W each  first and last threshold codes.
REQ-008 dac_step  in  DAC_W  code increment; 0 treated as 1.
REQ-009 settle_cycles  in  16  clk cycles waited after each DAC load.
REQ-010 cnt_max_in  in  CNT_W  pulse count per step.
REQ-011 dac_code  out  DAC_W  current threshold code.
REQ-012 dac_load  out  1  one-cycle strobe when dac_code changes.
REQ-013 test_start  out  1  level enable to the S-curve counter.
REQ-014 cpt_max  out  CNT_W  pulse target to the counter.
REQ-015 cpt_pulse, cpt_trigger  in  CNT_W each  counter results.
REQ-016 cpt_done  in  1  counter completion, level, synchronous to clk.
REQ-017 res_data  out  CNT_W  result word; res_valid out 1; res_ready in 1.
REQ-018 scan_busy  out  1  high from accepted scan_start until return to IDLE.
REQ-019 scan_done  out  1  one-cycle pulse on normal completion.

Function
REQ-020 States SHALL be IDLE, LOAD, SETTLE, COUNT, SEND_HDR, SEND_PLS, SEND_TRG, NEXT, FINISH.
REQ-021 IDLE + scan_start: latch dac_start/dac_stop/step/settle_cycles/cnt_max_in; dac_code<=dac_start; go LOAD.
REQ-022 LOAD: dac_load=1 for exactly one cycle; go SETTLE with settle counter cleared.
REQ-023 SETTLE: wait settle_cycles cycles; settle_cycles=0 -> COUNT on the next cycle.
REQ-024 COUNT: test_start=1; on first cycle with cpt_done=1 latch cpt_pulse/cpt_trigger, go SEND_HDR; test_start SHALL be 0 in that next cycle.
REQ-025 test_start SHALL be low at least two cycles between consecutive steps (guaranteed by LOAD+SETTLE).
REQ-026 cpt_max SHALL equal latched cnt_max_in while busy, 0 in IDLE.
REQ-027 Words: SEND_HDR {4'hA, zero pad, dac_code}; SEND_PLS latched pulse count; SEND_TRG latched trigger count.
REQ-028 Handshake: res_valid high in SEND_*; word transfers when res_valid&res_ready; res_data stable while res_valid&!res_ready; state advances only on transfer.
REQ-029 NEXT: dac_code==dac_stop -> FINISH; else move toward dac_stop by step, clamped to dac_stop if step overshoots; go LOAD.
REQ-030 Direction: ascending if dac_start<=dac_stop, else descending; dac_start==dac_stop gives exactly one step.
REQ-031 FINISH: scan_done=1 one cycle; go IDLE.
REQ-032 scan_abort in any non-IDLE state: next cycle IDLE, test_start=0, res_valid=0, no scan_done; dac_code held.
REQ-033 scan_start and scan_abort simultaneous in IDLE: abort wins, stay IDLE.
REQ-034 No combinational path from any input to any output.

Reset
REQ-035 reset_n low: state IDLE; dac_code, cpt_max, res_data, latched counts 0; dac_load, test_start, res_valid, scan_busy, scan_done 0.
REQ-036 Reset mid-scan SHALL take effect asynchronously; no further words emitted.

Structure
REQ-037 Shared package scurve_pkg: state encoding, header tag 4'hA, DAC_W/CNT_W defaults.
REQ-038 Single sub-module scurve_step_calc: combinational next-code/last-step computation (direction, clamp, step=0 -> 1).
REQ-039 The counter SHALL remain a separate block; this module only drives its interface.

Verification
REQ-040 start=100, stop=103, step=1, settle=5, max=1000, counter model returns trigger=500, res_ready=1 -> 12 words, headers 0xA064..0xA067, pulse words 1000, scan_done once.
REQ-041 start=10, stop=0, step=4 -> headers at codes 10, 6, 2, 0 (clamped), 4 steps.
REQ-042 res_ready low 20 cycles during SEND_PLS -> res_data/res_valid held constant, no word lost or duplicated.
REQ-043 scan_abort asserted in COUNT -> test_start 0 next cycle, IDLE, no scan_done; new scan_start then runs normally.
REQ-044 start=stop=512, step=0, settle=0 -> one step, dac_load exactly once, 3 words, scan_done.
REQ-045 reset_n low mid SETTLE -> all outputs at REQ-035 values immediately; scan_start ignored while busy.
